// File: rtl/i2c_pkg.sv
// Shared definitions for the serial slave controller: FSM encodings and frame geometry.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_ACK  = 3'd2,
    ST_DATA = 3'd3,
    ST_SKIP = 3'd4
  } state_t;

  localparam int FRAME_BITS = 18;
  // A non-matching slave sits out the ACK period plus the eight data periods.
  localparam int SKIP_BITS = FRAME_BITS - 9;
  localparam logic [3:0] SKIP_LAST = 4'(SKIP_BITS - 1);

endpackage

// File: rtl/sclk_edge_det.sv
// Brings SCLK and RX into the CLK domain and flags synchronised SCLK rising/falling edges.
module sclk_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_rx,
  output logic o_rise,
  output logic o_fall,
  output logic o_rx_sync
);

  logic [1:0] r_sclk_sync;
  logic       r_sclk_prev;
  logic [1:0] r_rx_sync;

  // Everything idles high out of reset so the line-idle state is not seen as an edge into high.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sclk_sync <= 2'b11;
      r_sclk_prev <= 1'b1;
      r_rx_sync   <= 2'b11;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], i_sclk};
      r_sclk_prev <= r_sclk_sync[1];
      r_rx_sync   <= {r_rx_sync[0], i_rx};
    end
  end

  assign o_rise    = r_sclk_sync[1] & ~r_sclk_prev;
  assign o_fall    = ~r_sclk_sync[1] & r_sclk_prev;
  assign o_rx_sync = r_rx_sync[1];

endmodule

// File: rtl/i2c_slave_ctrl.sv
// Serial slave: receives a start bit and 8-bit address, acknowledges a match and returns one data byte.
module i2c_slave_ctrl
  import i2c_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCLK,
  input  logic       RX,
  input  logic [7:0] ADDR,
  input  logic [7:0] DATA,
  output logic       OUT,
  output logic       BUSY,
  output logic       MATCH,
  output logic       DONE
);

  logic       w_rise;
  logic       w_fall;
  logic       w_rx;

  state_t     r_state,    w_state_nxt;
  logic [2:0] r_bit_cnt,  w_bit_cnt_nxt;
  logic [3:0] r_skip_cnt, w_skip_cnt_nxt;
  logic [7:0] r_shift,    w_shift_nxt;
  logic [7:0] r_tx,       w_tx_nxt;
  logic       r_out,      w_out_nxt;
  logic       r_match,    w_match_nxt;
  logic       r_done,     w_done_nxt;
  logic [7:0] w_addr_rx;

  sclk_edge_det u_edge (
    .i_clk     (CLK),
    .i_rst_n   (RST_N),
    .i_sclk    (SCLK),
    .i_rx      (RX),
    .o_rise    (w_rise),
    .o_fall    (w_fall),
    .o_rx_sync (w_rx)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_skip_cnt <= 4'd0;
      r_shift    <= 8'd0;
      r_tx       <= 8'd0;
      r_out      <= 1'b0;
      r_match    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_skip_cnt <= w_skip_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_out      <= w_out_nxt;
      r_match    <= w_match_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // RX is only sampled on SCLK rises; OUT only moves on SCLK falls so it is stable when the master samples.
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_skip_cnt_nxt = r_skip_cnt;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = r_tx;
    w_out_nxt      = r_out;
    w_match_nxt    = r_match;
    w_done_nxt     = 1'b0;
    w_addr_rx      = {r_shift[6:0], w_rx};

    case (r_state)
      ST_IDLE: begin
        if (w_rise && !w_rx) begin
          w_state_nxt   = ST_ADDR;
          w_bit_cnt_nxt = 3'd0;
        end
      end
      ST_ADDR: begin
        if (w_rise) begin
          w_shift_nxt   = w_addr_rx;
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_bit_cnt_nxt = 3'd0;
            if (w_addr_rx == ADDR) begin
              w_state_nxt = ST_ACK;
              w_match_nxt = 1'b1;
              w_tx_nxt    = DATA;
            end else begin
              w_state_nxt    = ST_SKIP;
              w_skip_cnt_nxt = 4'd0;
            end
          end
        end
      end
      ST_ACK: begin
        if (w_fall) begin
          w_out_nxt = 1'b1;
        end else if (w_rise) begin
          w_state_nxt   = ST_DATA;
          w_bit_cnt_nxt = 3'd0;
        end
      end
      ST_DATA: begin
        if (w_fall) begin
          w_out_nxt = r_tx[~r_bit_cnt];
        end else if (w_rise) begin
          // The rise with the count at 7 is the master sampling bit 0, which closes the frame.
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = 3'd0;
            w_out_nxt     = 1'b0;
            w_match_nxt   = 1'b0;
            w_done_nxt    = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      ST_SKIP: begin
        if (w_rise) begin
          if (r_skip_cnt == SKIP_LAST) begin
            w_state_nxt    = ST_IDLE;
            w_bit_cnt_nxt  = 3'd0;
            w_skip_cnt_nxt = 4'd0;
          end else begin
            w_skip_cnt_nxt = r_skip_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign OUT   = r_out;
  assign BUSY  = (r_state != ST_IDLE);
  assign MATCH = r_match;
  assign DONE  = r_done;

endmodule
